// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, idle-high line.
// Two-flop synchroniser on Rx_in, mid-bit start validation, centre sampling of
// each data bit, stop-bit check and one-cycle registered result strobes.
// Optional even-parity bit enabled by defining UART_RX_PARITY_EN; without it
// Rx_Parity_Err_out is constant 0.
// Rx_State_dbg_out exposes the FSM state code for observation.
module uart_rx #(
    parameter int CLKS_PER_BIT = 234
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       Rx_in,
    output logic       Rx_DV_out,
    output logic [7:0] Rx_Byte_out,
    output logic       Rx_Active_out,
    output logic       Rx_Frame_Err_out,
    output logic       Rx_Parity_Err_out,
    output logic [2:0] Rx_State_dbg_out
);

    localparam logic [7:0] HALF = 8'((CLKS_PER_BIT - 1) / 2);
    localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_START   = 3'd1,
        S_DATA    = 3'd2,
        S_PARITY  = 3'd3,
        S_STOP    = 3'd4,
        S_CLEANUP = 3'd5
    } state_e;

    state_e     state_q, state_d;
    logic       sync1_q, sync2_q;
    logic [7:0] count_q, count_d;
    logic [2:0] index_q, index_d;
    logic [7:0] shift_q, shift_d;
    logic [7:0] byte_q, byte_d;
    logic       dv_q, dv_d;
    logic       active_q, active_d;
    logic       ferr_q, ferr_d;
    logic       rx_s;
`ifdef UART_RX_PARITY_EN
    logic       perr_q, perr_d;
    logic       par_bad_q, par_bad_d;
`endif

    assign rx_s = sync2_q;

    // State register, synchroniser and registered outputs
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            sync1_q  <= 1'b1;
            sync2_q  <= 1'b1;
            state_q  <= S_IDLE;
            count_q  <= 8'd0;
            index_q  <= 3'd0;
            shift_q  <= 8'd0;
            byte_q   <= 8'd0;
            dv_q     <= 1'b0;
            active_q <= 1'b0;
            ferr_q   <= 1'b0;
`ifdef UART_RX_PARITY_EN
            perr_q    <= 1'b0;
            par_bad_q <= 1'b0;
`endif
        end else begin
            sync1_q  <= Rx_in;
            sync2_q  <= sync1_q;
            state_q  <= state_d;
            count_q  <= count_d;
            index_q  <= index_d;
            shift_q  <= shift_d;
            byte_q   <= byte_d;
            dv_q     <= dv_d;
            active_q <= active_d;
            ferr_q   <= ferr_d;
`ifdef UART_RX_PARITY_EN
            perr_q    <= perr_d;
            par_bad_q <= par_bad_d;
`endif
        end
    end

    // Next-state and output logic; strobes default low so they last one cycle
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        index_d  = index_q;
        shift_d  = shift_q;
        byte_d   = byte_q;
        dv_d     = 1'b0;
        ferr_d   = 1'b0;
        active_d = active_q;
`ifdef UART_RX_PARITY_EN
        perr_d    = 1'b0;
        par_bad_d = par_bad_q;
`endif
        case (state_q)
            S_IDLE: begin
                count_d  = 8'd0;
                index_d  = 3'd0;
                active_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
                if (!rx_s) begin
                    state_d  = S_START;
                    active_d = 1'b1;
                end
            end
            S_START: begin
                if (count_q == HALF) begin
                    count_d = 8'd0;
                    if (!rx_s) begin
                        state_d = S_DATA;
                    end else begin
                        // Start bit no longer low at mid-bit: treat as a glitch
                        state_d  = S_IDLE;
                        active_d = 1'b0;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            S_DATA: begin
                if (count_q == LAST) begin
                    count_d          = 8'd0;
                    shift_d[index_q] = rx_s;
                    if (index_q != 3'd7) begin
                        index_d = index_q + 3'd1;
                    end else begin
                        index_d = 3'd0;
`ifdef UART_RX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (count_q == LAST) begin
                    count_d   = 8'd0;
                    par_bad_d = ^{shift_q, rx_s};
                    state_d   = S_STOP;
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
`endif
            S_STOP: begin
                if (count_q == LAST) begin
                    count_d = 8'd0;
                    state_d = S_CLEANUP;
`ifdef UART_RX_PARITY_EN
                    perr_d = par_bad_q;
                    if (rx_s && !par_bad_q) begin
`else
                    if (rx_s) begin
`endif
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end
                    if (!rx_s) begin
                        ferr_d = 1'b1;
                    end
                end else begin
                    count_d = count_q + 8'd1;
                end
            end
            S_CLEANUP: begin
                active_d = 1'b0;
                state_d  = S_IDLE;
            end
            default: begin
                state_d  = S_IDLE;
                count_d  = 8'd0;
                index_d  = 3'd0;
                shift_d  = 8'd0;
                byte_d   = 8'd0;
                active_d = 1'b0;
`ifdef UART_RX_PARITY_EN
                par_bad_d = 1'b0;
`endif
            end
        endcase
    end

    assign Rx_DV_out        = dv_q;
    assign Rx_Byte_out      = byte_q;
    assign Rx_Active_out    = active_q;
    assign Rx_Frame_Err_out = ferr_q;
    assign Rx_State_dbg_out = state_q;
`ifdef UART_RX_PARITY_EN
    assign Rx_Parity_Err_out = perr_q;
`else
    assign Rx_Parity_Err_out = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames into a fast receiver (16 clocks/bit) and a
// slow one (234 clocks/bit) playing the transmitter's counterpart.
// Expected result strobes (kind, byte, cycle) are queued by the driver and
// popped by an independent monitor whenever either receiver strobes.
module tb_uart_rx;

    localparam int FAST_CPB = 16;
    localparam int SLOW_CPB = 234;
`ifdef UART_RX_PARITY_EN
    localparam int PB = 1;
`else
    localparam int PB = 0;
`endif

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       rx_fast = 1'b1;
    logic       rx_slow = 1'b1;
    logic       f_dv, f_active, f_ferr, f_perr;
    logic [7:0] f_byte;
    logic [2:0] f_state;
    logic       s_dv, s_active, s_ferr, s_perr;
    logic [7:0] s_byte;
    logic [2:0] s_state;

    uart_rx #(.CLKS_PER_BIT(FAST_CPB)) u_fast (
        .CLK(clk), .RST_N(rst_n), .Rx_in(rx_fast),
        .Rx_DV_out(f_dv), .Rx_Byte_out(f_byte), .Rx_Active_out(f_active),
        .Rx_Frame_Err_out(f_ferr), .Rx_Parity_Err_out(f_perr),
        .Rx_State_dbg_out(f_state)
    );

    uart_rx #(.CLKS_PER_BIT(SLOW_CPB)) u_slow (
        .CLK(clk), .RST_N(rst_n), .Rx_in(rx_slow),
        .Rx_DV_out(s_dv), .Rx_Byte_out(s_byte), .Rx_Active_out(s_active),
        .Rx_Frame_Err_out(s_ferr), .Rx_Parity_Err_out(s_perr),
        .Rx_State_dbg_out(s_state)
    );

    // ---------------- scoreboard ----------------
    // entry = {dv, frame_err, parity_err, byte[7:0], strobe cycle[31:0]}
    logic [42:0] exp_q[$];
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] last_good[2] = '{8'h00, 8'h00};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic mon_check(input string name, input logic dv, input logic fe,
                             input logic pe, input logic [7:0] b);
        logic [42:0] e;
        vectors++;
        if (exp_q.size() == 0) begin
            miscompares++;
            $display("FAIL %s: got dv=%b fe=%b pe=%b byte=%02h at cycle %0d, expected no strobe",
                     name, dv, fe, pe, b, cyc);
        end else begin
            e = exp_q.pop_front();
            if ({dv, fe, pe, b, 32'(cyc)} !== e) begin
                miscompares++;
                $display("FAIL %s: got dv=%b fe=%b pe=%b byte=%02h cycle=%0d, expected dv=%b fe=%b pe=%b byte=%02h cycle=%0d",
                         name, dv, fe, pe, b, cyc, e[42], e[41], e[40], e[39:32], e[31:0]);
            end
        end
    endtask

    // Monitor: any strobe on either receiver must match the head of the queue
    always @(negedge clk) begin
        if (rst_n) begin
            if (f_dv || f_ferr || f_perr) mon_check("strobe_fast", f_dv, f_ferr, f_perr, f_byte);
            if (s_dv || s_ferr || s_perr) mon_check("strobe_slow", s_dv, s_ferr, s_perr, s_byte);
        end
    end

    // ---------------- driver tasks ----------------
    // All tasks start and end 1 time unit after a rising edge.
    task automatic align();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit sel, input logic v);
        if (sel) rx_slow = v;
        else     rx_fast = v;
    endtask

    task automatic send_frame(input bit sel, input logic [7:0] data,
                              input logic stop_bit, input bit par_flip);
        int cpb, c0, nb;
        logic good, fe, pe;
        logic [7:0] eb;
        logic [10:0] bits;
        cpb = sel ? SLOW_CPB : FAST_CPB;
        c0  = cyc;
`ifdef UART_RX_PARITY_EN
        pe   = par_flip;
        bits = {stop_bit, (^data) ^ par_flip, data, 1'b0};
        nb   = 11;
`else
        pe   = 1'b0;
        bits = {1'b1, stop_bit, data, 1'b0};
        nb   = 10;
`endif
        fe   = ~stop_bit;
        good = stop_bit & ~pe;
        if (good) last_good[sel] = data;
        eb = last_good[sel];
        // Pin change at c0 reaches the FSM at c0+3; stop sampled HALF+1+(9+PB)*cpb later
        exp_q.push_back({good, fe, pe, eb, 32'(c0 + 4 + (cpb - 1) / 2 + (9 + PB) * cpb)});
        for (int i = 0; i < nb; i++) begin
            set_line(sel, bits[i]);
            idle(cpb);
        end
        set_line(sel, 1'b1);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] partial;
        partial = 8'h3C;

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_dv", f_dv, 0);
        check("reset_byte", f_byte, 8'h00);
        check("reset_active", f_active, 0);
        check("reset_frame_err", f_ferr, 0);
        check("reset_parity_err", f_perr, 0);
        align();
        rst_n = 1'b1;
        idle(5);

        // Clean frame 0xA5
        send_frame(0, 8'hA5, 1'b1, 1'b0);
        @(negedge clk);
        check("a5_active_after_cleanup", f_active, 0);
        check("a5_byte_held", f_byte, 8'hA5);
        align();
        idle(20);

        // 4-cycle low glitch on idle line
        rx_fast = 1'b0;
        idle(4);
        rx_fast = 1'b1;
        @(negedge clk);
        check("glitch_start_entered", f_active, 1);
        align();
        idle(12);
        @(negedge clk);
        check("glitch_back_to_idle", f_active, 0);
        check("glitch_byte_unchanged", f_byte, 8'hA5);
        align();
        idle(20);

        // Frame 0x3C with stop bit low
        send_frame(0, 8'h3C, 1'b0, 1'b0);
        idle(40);
        @(negedge clk);
        check("ferr_byte_kept", f_byte, 8'hA5);
        align();

        // Back-to-back frames, no idle gap
        send_frame(0, 8'h00, 1'b1, 1'b0);
        send_frame(0, 8'hFF, 1'b1, 1'b0);
        send_frame(0, 8'h81, 1'b1, 1'b0);
        idle(30);

        // Reset pulse during data bit 4 of a partial frame
        rx_fast = 1'b0;
        idle(FAST_CPB);
        for (int i = 0; i < 4; i++) begin
            rx_fast = partial[i];
            idle(FAST_CPB);
        end
        rx_fast = partial[4];
        idle(FAST_CPB / 2);
        @(negedge clk);
        check("midframe_active", f_active, 1);
        align();
        rst_n = 1'b0;
        align();
        rst_n   = 1'b1;
        rx_fast = 1'b1;
        last_good[0] = 8'h00;
        @(negedge clk);
        check("midreset_dv", f_dv, 0);
        check("midreset_byte", f_byte, 8'h00);
        check("midreset_active", f_active, 0);
        check("midreset_frame_err", f_ferr, 0);
        check("midreset_parity_err", f_perr, 0);
        align();
        idle(40);
        send_frame(0, 8'h7E, 1'b1, 1'b0);
        idle(20);

`ifdef UART_RX_PARITY_EN
        // 0x07: even parity bit is 1
        send_frame(0, 8'h07, 1'b1, 1'b0);
        idle(20);
        send_frame(0, 8'h07, 1'b1, 1'b1);
        idle(20);
        @(negedge clk);
        check("perr_byte_kept", f_byte, 8'h07);
        align();
`endif

        // Equal-rate link at 234 clocks per bit
        send_frame(1, 8'h55, 1'b1, 1'b0);
        idle(50);

        check("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Watchdog
    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: got timeout at cycle %0d, expected completion", cyc);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial UART receiver, 8N1 framing (optional even parity), LSB first, line idle high. Counterpart of the on-chip transmitter; same `CLKS_PER_BIT` bit timing, so a transmitter and receiver built with equal parameters interoperate on one link. Synchronises the asynchronous `Rx_in` pin, validates the start bit at mid-bit, samples each data bit at its centre, checks the stop bit, and presents each received byte with a one-cycle valid strobe.

## Interface
- `CLKS_PER_BIT`, 234: CLK cycles per serial bit; legal range 4..255 (8-bit counter).
- `CLK`  input  1  system clock; all logic on rising edge.
- `RST_N`  input  1  synchronous, active-low reset.
- `Rx_in`  input  1  asynchronous serial line, idle high.
- `Rx_DV_out`  output  1  one-cycle pulse: `Rx_Byte_out` updated with a good frame.
- `Rx_Byte_out`  output  8  last good byte; held until next good frame.
- `Rx_Active_out`  output  1  high from accepted start edge until return to IDLE.
- `Rx_Frame_Err_out`  output  1  one-cycle pulse: stop bit sampled low.
- `Rx_Parity_Err_out`  output  1  one-cycle pulse: parity mismatch (tied 0 without `UART_RX_PARITY_EN`).

## Operation
- Synchroniser: two flops on `Rx_in`, both reset to 1; FSM uses only synchronised `rx_s`.
- `HALF` = (`CLKS_PER_BIT`-1)/2, integer division. Counter 8 bits, bit index 3 bits.
- States: IDLE, START, DATA, PARITY (macro only), STOP, CLEANUP; encoded in 3 bits; unused codes go to IDLE with all outputs at reset values.
- IDLE: count=0, index=0, `Rx_Active_out`=0. `rx_s`=0 -> START, `Rx_Active_out`<=1.
- START: count increments. At count==`HALF`: `rx_s`=0 -> DATA, count<=0; `rx_s`=1 -> IDLE (glitch rejected, no strobe, no error).
- DATA: count increments; at count==`CLKS_PER_BIT`-1: shift register[index]<=`rx_s`, count<=0; index<7 -> index+1; index==7 -> index<=0, next PARITY (macro) or STOP.
- PARITY: at count==`CLKS_PER_BIT`-1 sample `rx_s`; mismatch flag set if XOR(data bits, sampled bit)!=0 (even parity); -> STOP.
- STOP: at count==`CLKS_PER_BIT`-1 sample `rx_s`: 1 and no parity mismatch -> `Rx_Byte_out`<=shift reg, `Rx_DV_out`<=1; 0 -> `Rx_Frame_Err_out`<=1, byte not updated; parity mismatch -> `Rx_Parity_Err_out`<=1, byte not updated. Both errors may pulse together. -> CLEANUP.
- CLEANUP: strobes return to 0, `Rx_Active_out`<=0, -> IDLE. Line must be seen high in IDLE? No: a low `rx_s` in IDLE immediately starts a new frame (back-to-back frames supported; framing-error break condition restarts repeatedly).

## Timing
- Reset (`RST_N`=0 at an edge, any state including mid-frame): state IDLE, sync flops 1, count 0, index 0, `Rx_DV_out`=0, `Rx_Byte_out`=8'h00, `Rx_Active_out`=0, `Rx_Frame_Err_out`=0, `Rx_Parity_Err_out`=0. Partial frame discarded.
- Pin-to-FSM latency: 2 cycles.
- Edge E0 = IDLE edge seeing `rx_s`=0. Start check at E0+`HALF`+1; data bit k sampled at E0+`HALF`+1+(k+1)·`CLKS_PER_BIT`; stop sampled at E0+`HALF`+1+9·`CLKS_PER_BIT` (+`CLKS_PER_BIT` with parity); strobes high for the following cycle only.
- Strobes are registered; never high two consecutive cycles.
- No backpressure: consumer must capture `Rx_Byte_out` on `Rx_DV_out`; byte remains stable ≥1 frame.

## Configuration
- `UART_RX_PARITY_EN` defined: PARITY state present, frame is start+8 data+even parity+stop (11 bits), `Rx_Parity_Err_out` live.
- Undefined: 8N1 only, PARITY state absent, `Rx_Parity_Err_out` constant 0.

## Test plan
- `CLKS_PER_BIT`=16, drive 8N1 frame 0xA5 -> one `Rx_DV_out` pulse at stop-sample+1, `Rx_Byte_out`=0xA5, no error pulses, `Rx_Active_out` low after CLEANUP.
- Low glitch of 4 cycles on idle line -> START entered, returns to IDLE at mid-bit, no strobes, `Rx_Byte_out` unchanged.
- Frame 0x3C with stop bit driven 0 -> `Rx_Frame_Err_out` one-cycle pulse, `Rx_DV_out` stays 0, `Rx_Byte_out` keeps prior value.
- Back-to-back frames 0x00, 0xFF, 0x81 with no idle gap -> three `Rx_DV_out` pulses, bytes in order; also loopback from transmitter with equal `CLKS_PER_BIT`=234 for 0x55.
- `RST_N` asserted for one cycle during data bit 4 -> all outputs reset next edge; subsequent clean frame 0x7E received correctly.
- With `UART_RX_PARITY_EN`: 0x07 with parity 1 -> DV, byte 0x07; with parity 0 -> `Rx_Parity_Err_out` pulse, no DV.
